// File: rtl/mult_req_sequencer.sv
// mult_req_sequencer: requester-side sequencer for the hex multiplier datapath.
// Accepts operand pairs over a valid/ready handshake, drives the multiplier
// controller's start/enable pins, waits for done (guarded by a saturating
// watchdog) and presents the product downstream over a second handshake.
// Optional feature macro: MULT_SEQ_ZERO_SKIP_EN (a zero operand bypasses the
// multiplier and goes straight to HOLD with a zero product).
module mult_req_sequencer #(
  parameter int W       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           mul_start,
  output logic           mul_enable,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_product,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_product,
  output logic           out_error,
  output logic           busy,
  output logic [2:0]     seq_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ABORT = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // Last watchdog value tolerated in WAIT before the job is aborted.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] wdog_r;
  logic       accept_s;
  logic       zero_skip_s;

  assign accept_s  = (state_r == ST_IDLE) && in_valid;
  assign seq_state = state_r;

`ifdef MULT_SEQ_ZERO_SKIP_EN
  assign zero_skip_s = (in_a == {W{1'b0}}) || (in_b == {W{1'b0}});
`else
  assign zero_skip_s = 1'b0;
`endif

  // Next-state decode for the job sequencing FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (zero_skip_s) begin
            state_next_s = ST_HOLD;
          end else begin
            state_next_s = ST_ISSUE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (mul_done) begin
          state_next_s = ST_HOLD;
        end else if (wdog_r == WDOG_LAST) begin
          state_next_s = ST_ABORT;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_ABORT: begin
        state_next_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Control outputs registered from the next state, so they always match seq_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b1;
      mul_start  <= 1'b0;
      mul_enable <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      in_ready   <= (state_next_s == ST_IDLE);
      mul_start  <= (state_next_s == ST_ISSUE);
      mul_enable <= (state_next_s == ST_ISSUE) || (state_next_s == ST_WAIT);
      out_valid  <= (state_next_s == ST_HOLD);
      busy       <= (state_next_s != ST_IDLE);
    end
  end

  // Operand capture, only on the IDLE handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= {W{1'b0}};
      mul_b <= {W{1'b0}};
    end else if (accept_s) begin
      mul_a <= in_a;
      mul_b <= in_b;
    end else begin
      mul_a <= mul_a;
      mul_b <= mul_b;
    end
  end

  // Watchdog: cleared on accept, counts WAIT cycles and saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_r <= 8'd0;
    end else if (accept_s) begin
      wdog_r <= 8'd0;
    end else if ((state_r == ST_WAIT) && (wdog_r != 8'hFF)) begin
      wdog_r <= wdog_r + 8'd1;
    end else begin
      wdog_r <= wdog_r;
    end
  end

  // Result capture: product on done, zero with error on abort, zero on a skipped job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_product <= {(2*W){1'b0}};
      out_error   <= 1'b0;
    end else if (accept_s && zero_skip_s) begin
      out_product <= {(2*W){1'b0}};
      out_error   <= 1'b0;
    end else if ((state_r == ST_WAIT) && mul_done) begin
      out_product <= mul_product;
      out_error   <= 1'b0;
    end else if (state_r == ST_ABORT) begin
      out_product <= {(2*W){1'b0}};
      out_error   <= 1'b1;
    end else begin
      out_product <= out_product;
      out_error   <= out_error;
    end
  end

endmodule

// File: tb/tb_mult_req_sequencer.sv
// Self-checking bench for mult_req_sequencer: table-driven jobs, hand-written
// stray-done and mid-job reset sequences, and randomized jobs checked against
// a plain a*b reference. Includes a small controller model that answers a
// start pulse with a done pulse a programmable number of edges later.
module tb_mult_req_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'd0;
  logic [7:0]  in_b = 8'd0;
  logic        mul_start;
  logic        mul_enable;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_done;
  logic [15:0] mul_product;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_product;
  logic        out_error;
  logic        busy;
  logic [2:0]  seq_state;

  int total = 0;
  int bad   = 0;

`ifdef MULT_SEQ_ZERO_SKIP_EN
  localparam bit ZS_EN     = 1'b1;
  localparam int ZS_LAT    = 0;
  localparam int ZS_WAIT   = 0;
  localparam int ZS_STARTS = 0;
`else
  localparam bit ZS_EN     = 1'b0;
  localparam int ZS_LAT    = 8;
  localparam int ZS_WAIT   = 7;
  localparam int ZS_STARTS = 1;
`endif

  mult_req_sequencer #(.W(8), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mul_start   (mul_start),
    .mul_enable  (mul_enable),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_error   (out_error),
    .busy        (busy),
    .seq_state   (seq_state)
  );

  always #5 clk = ~clk;

  // Controller model: done is seen by the sequencer done_delay+2 edges after
  // the start cycle's edge (6 -> sampled at the 8th edge after accept);
  // done_delay of 0 means the controller never answers.
  int          done_delay = 6;
  int          cnt = 0;
  logic        model_done = 1'b0;
  logic [15:0] model_prod = 16'd0;
  logic        stray_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n || !mul_enable) begin
      cnt = 0;
    end else if (mul_start) begin
      cnt = (done_delay > 0) ? done_delay + 2 : 0;
      model_prod = 16'(mul_a) * 16'(mul_b);
    end else if (cnt > 0) begin
      cnt = cnt - 1;
    end
    model_done = (cnt == 1);
  end

  assign mul_done    = model_done | stray_done;
  assign mul_product = model_done ? model_prod : 16'hDEAD;

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string nm);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          rdy_dly;
    int          dly;
    logic [15:0] exp_p;
    logic        exp_e;
    int          exp_lat;
    int          exp_wait;
    int          exp_starts;
  } vec_t;

  vec_t vecs[7];

  // One complete job: handshake, latency / protocol bookkeeping, result check,
  // optional back-pressure (with a stray done during HOLD), release to IDLE.
  task automatic run_job(input vec_t v, input string nm);
    int lat;
    int starts;
    int waits;
    int aborts;
    int rdy_bad;
    int guard;
    logic [15:0] held;
    done_delay = v.dly;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check(32'(in_ready), 32'd1, {nm, "_in_ready_idle"});
    in_a = v.a;
    in_b = v.b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 8'($urandom);
    in_b = 8'($urandom);
    lat = 0; starts = 0; waits = 0; aborts = 0; rdy_bad = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (out_valid) break;
      if (mul_start) starts++;
      if (seq_state == 3'd2) waits++;
      if (seq_state == 3'd3 && !mul_enable) aborts++;
      if (in_ready) rdy_bad++;
      @(posedge clk);
      lat++;
    end
    check(32'(out_valid), 32'd1, {nm, "_out_valid"});
    check(32'(lat), 32'(v.exp_lat), {nm, "_latency"});
    check(32'(starts), 32'(v.exp_starts), {nm, "_start_pulses"});
    check(32'(waits), 32'(v.exp_wait), {nm, "_wait_cycles"});
    check(32'(aborts), 32'(v.exp_e), {nm, "_abort_cycles"});
    check(32'(rdy_bad), 32'd0, {nm, "_in_ready_busy"});
    check(32'(out_product), 32'(v.exp_p), {nm, "_product"});
    check(32'(out_error), 32'(v.exp_e), {nm, "_error"});
    check(32'(busy), 32'd1, {nm, "_busy_hold"});
    held = out_product;
    for (int i = 0; i < v.rdy_dly; i++) begin
      if (i == 0 && v.rdy_dly >= 2) stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      check(32'(out_valid), 32'd1, {nm, "_bp_valid"});
      check(32'(in_ready), 32'd0, {nm, "_bp_in_ready"});
      check(32'(out_product), 32'(held), {nm, "_bp_stable"});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check(32'(seq_state), 32'd0, {nm, "_back_idle"});
    check(32'(out_valid), 32'd0, {nm, "_valid_drop"});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t rv;
    logic [7:0] ra;
    logic [7:0] rb;
    int vcount;
    logic is_zero;

    //        a      b      rdy dly exp_p     e     lat     wait     starts
    vecs[0] = '{8'h3A, 8'h17, 0, 6,  16'h0536, 1'b0, 8,      7,       1};
    vecs[1] = '{8'hFF, 8'hFF, 5, 6,  16'hFE01, 1'b0, 8,      7,       1};
    vecs[2] = '{8'h01, 8'h80, 0, 6,  16'h0080, 1'b0, 8,      7,       1};
    vecs[3] = '{8'h12, 8'h34, 2, 0,  16'h0000, 1'b1, 17,     15,      1};
    vecs[4] = '{8'h7F, 8'h02, 1, 14, 16'h00FE, 1'b0, 16,     15,      1};
    vecs[5] = '{8'h00, 8'hFF, 0, 6,  16'h0000, 1'b0, ZS_LAT, ZS_WAIT, ZS_STARTS};
    vecs[6] = '{8'h10, 8'h10, 3, 6,  16'h0100, 1'b0, 8,      7,       1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check(32'(seq_state), 32'd0, "rst_state");
    check(32'(in_ready), 32'd1, "rst_in_ready");
    check(32'({mul_start, mul_enable}), 32'd0, "rst_start_enable");
    check(32'({mul_a, mul_b}), 32'd0, "rst_operands");
    check(32'({out_valid, out_error, busy}), 32'd0, "rst_valid_err_busy");
    check(32'(out_product), 32'd0, "rst_product");

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i], $sformatf("vec%0d", i));
    end

    // Stray done while idle must not move the FSM or touch the result.
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    check(32'(seq_state), 32'd0, "stray_idle_state");
    check(32'(out_valid), 32'd0, "stray_idle_valid");
    check(32'(out_product), 32'h0100, "stray_idle_product");

    // Reset pulsed during WAIT: outputs return to reset values at once.
    done_delay = 6;
    in_a = 8'h5A;
    in_b = 8'hC3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check(32'(seq_state), 32'd2, "midrst_in_wait");
    #2;
    rst_n = 1'b0;
    #1;
    check(32'(seq_state), 32'd0, "midrst_state");
    check(32'(in_ready), 32'd1, "midrst_in_ready");
    check(32'({mul_start, mul_enable}), 32'd0, "midrst_start_enable");
    check(32'({mul_a, mul_b}), 32'd0, "midrst_operands");
    check(32'({out_valid, out_error, busy}), 32'd0, "midrst_valid_err_busy");
    check(32'(out_product), 32'd0, "midrst_product");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check(32'(vcount), 32'd0, "midrst_no_result");
    run_job(vecs[0], "post_rst");

    // Randomized jobs against the a*b reference.
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      is_zero = (ra == 8'd0) || (rb == 8'd0);
      rv.a = ra;
      rv.b = rb;
      rv.rdy_dly = $urandom_range(0, 3);
      rv.dly = 6;
      rv.exp_p = 16'(ra) * 16'(rb);
      rv.exp_e = 1'b0;
      rv.exp_lat = (ZS_EN && is_zero) ? 0 : 8;
      rv.exp_wait = (ZS_EN && is_zero) ? 0 : 7;
      rv.exp_starts = (ZS_EN && is_zero) ? 0 : 1;
      run_job(rv, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
